wb_mem_responder: RTL and testbench
===================================

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, giving log2 of the number of 64-bit memory words.
REQ-002 SHALL have parameter LATENCY, default 4 (legal range 1..16), giving the acceptance-to-response cycle count.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4 (legal range 1..LATENCY), giving the maximum number of accepted, unanswered requests.
REQ-004 clock  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wb_cyc  input  1  bus cycle active.
REQ-007 wb_stb  input  1  request strobe.
REQ-008 wb_we  input  1  1 = write, 0 = read.
REQ-009 wb_addr  input  32  word address; one word is 64 bits.
REQ-010 wb_data_in  input  64  write data.
REQ-011 wb_sel  input  8  byte enables; bit i selects data bits [8i+7:8i].
REQ-012 wb_stall  output  1  1 = request not accepted this cycle.
REQ-013 wb_ack  output  1  one-cycle completion pulse.
REQ-014 wb_err  output  1  one-cycle error-completion pulse.
REQ-015 wb_data_out  output  64  read data, valid while wb_ack is high.

Function
REQ-016 SHALL follow Wishbone pipelined mode; a request is accepted in a cycle where wb_cyc && wb_stb && !wb_stall.
REQ-017 SHALL drive wb_stall = (outstanding == MAX_OUTSTANDING), combinationally from registered state only.
REQ-018 SHALL update the memory on an accepted write in the acceptance cycle, writing only the bytes whose wb_sel bit is set.
REQ-019 SHALL capture the stored word for an accepted read; a read accepted one cycle after a write to the same address returns the new data.
REQ-020 SHALL return each response exactly LATENCY cycles after its acceptance, in acceptance order, with at most one response per cycle.
REQ-021 SHALL never assert wb_ack and wb_err in the same cycle.
REQ-022 SHALL drive wb_data_out to 0 when wb_ack is low, and on write acks.
REQ-023 Outstanding counter: +1 on accept, -1 on response, unchanged when both occur in the same cycle; it never exceeds MAX_OUTSTANDING.
REQ-024 SHALL discard all in-flight responses in the next cycle when wb_cyc is low: outstanding becomes 0 and no ack/err is issued for them; writes already applied are kept.
REQ-025 Requests presented while stalled SHALL have no effect; the requester holds them.

Reset
REQ-026 While reset is high: wb_stall=0, wb_ack=0, wb_err=0, wb_data_out=0, outstanding=0, and the delay line is cleared; memory contents are not reset.
REQ-027 Reset asserted mid-operation SHALL drop all pending responses; the first acceptance after reset deasserts is normal.

Configuration
REQ-028 Macro WB_RESP_ADDR_CHECK_EN: when defined, a request with wb_addr >= 2**DEPTH_LOG2 SHALL leave memory unchanged and complete with wb_err at normal latency.
REQ-029 Without WB_RESP_ADDR_CHECK_EN, the address SHALL wrap modulo 2**DEPTH_LOG2 and wb_err SHALL be tied 0.

Structure
REQ-030 The shared package wb_pkg SHALL hold WB_ADDR_W=32, WB_DATA_W=64, WB_SEL_W=8, and the response typedef {valid, err, data}.
REQ-031 The response pipeline SHALL be the sub-module wb_resp_delay: a LATENCY-stage shift register of the response typedef with synchronous flush.

Verification
REQ-032 Write addr 5, data 0x1122334455667788, sel 0xFF; then read addr 5 -> each ack exactly 4 cycles after its acceptance, read returns 0x1122334455667788.
REQ-033 Write addr 5 with sel 0x0F, data 0xAAAAAAAAAAAAAAAA; read addr 5 -> 0x11223344AAAAAAAA.
REQ-034 Issue 6 back-to-back reads with MAX_OUTSTANDING=4 -> stall asserted after the 4th acceptance, released the cycle after the first ack; 6 acks in order.
REQ-035 Accept 3 reads, then drop wb_cyc for 1 cycle before any ack -> no ack or err pulses follow; outstanding=0; next request has latency 4.
REQ-036 With WB_RESP_ADDR_CHECK_EN, write addr 0x400 (DEPTH_LOG2=10) -> wb_err after 4 cycles and addr 0 unchanged; without the macro, ack is returned and addr 0 is written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone widths, response bundle and byte-merge helper
// for the pipelined memory responder.
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 64;
  localparam int WB_SEL_W  = 8;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [WB_DATA_W-1:0] data;
  } wb_rsp_t;

  function automatic logic [WB_DATA_W-1:0] byte_merge(
    input logic [WB_DATA_W-1:0] i_old,
    input logic [WB_DATA_W-1:0] i_new,
    input logic [WB_SEL_W-1:0]  i_sel
  );
    logic [WB_DATA_W-1:0] v;
    v = i_old;
    for (int i = 0; i < WB_SEL_W; i++) begin
      if (i_sel[i]) begin
        v[8*i +: 8] = i_new[8*i +: 8];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/wb_resp_delay.sv
// Fixed-latency response pipe: LATENCY register stages of wb_rsp_t,
// all cleared at once by a synchronous flush.
module wb_resp_delay
  import wb_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic    i_clock,
  input  logic    i_flush,
  input  wb_rsp_t i_rsp,
  output wb_rsp_t o_rsp
);

  wb_rsp_t r_stage [LATENCY];

  // Shift one stage per cycle; flush drops everything in flight.
  always_ff @(posedge i_clock) begin
    if (i_flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_rsp;
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_rsp = r_stage[LATENCY-1];

endmodule

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone memory slave with fixed response latency.
// Optional macro WB_RESP_ADDR_CHECK_EN: out-of-range -> wb_err.
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int DEPTH_LOG2      = 10,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [WB_ADDR_W-1:0] wb_addr,
  input  logic [WB_DATA_W-1:0] wb_data_in,
  input  logic [WB_SEL_W-1:0]  wb_sel,
  output logic                 wb_stall,
  output logic                 wb_ack,
  output logic                 wb_err,
  output logic [WB_DATA_W-1:0] wb_data_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

`ifdef WB_RESP_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  logic [WB_DATA_W-1:0]  r_mem [DEPTH];
  logic [CNT_W-1:0]      r_outstanding;

  logic                  w_full;
  logic                  w_accept;
  logic                  w_oob;
  logic                  w_bad;
  logic                  w_flush;
  logic [DEPTH_LOG2-1:0] w_idx;
  wb_rsp_t               w_rsp_in;
  wb_rsp_t               w_rsp_out;

  assign w_full   = (r_outstanding == CNT_W'(MAX_OUTSTANDING));
  // Reset forces the bus outputs idle even before the count clears.
  assign wb_stall = w_full & ~reset;
  assign w_accept = wb_cyc & wb_stb & ~w_full & ~reset;
  assign w_idx    = wb_addr[DEPTH_LOG2-1:0];
  assign w_oob    = ((wb_addr >> DEPTH_LOG2) != '0);
  assign w_bad    = ADDR_CHECK & w_oob;
  assign w_flush  = reset | ~wb_cyc;

  // Byte-masked write in the acceptance cycle; no reset on storage.
  always_ff @(posedge clock) begin
    if (w_accept && wb_we && !w_bad) begin
      r_mem[w_idx] <= byte_merge(r_mem[w_idx], wb_data_in, wb_sel);
    end
  end

  // Build the response at acceptance; writes carry zero data.
  always_comb begin
    w_rsp_in       = '0;
    w_rsp_in.valid = w_accept;
    w_rsp_in.err   = w_accept & w_bad;
    if (w_accept && !wb_we && !w_bad) begin
      w_rsp_in.data = r_mem[w_idx];
    end
  end

  wb_resp_delay #(
    .LATENCY (LATENCY)
  ) u_delay (
    .i_clock (clock),
    .i_flush (w_flush),
    .i_rsp   (w_rsp_in),
    .o_rsp   (w_rsp_out)
  );

  // Track accepted-but-unanswered requests; a flush empties the pipe.
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_outstanding <= '0;
    end else begin
      unique case ({w_accept, w_rsp_out.valid})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign wb_ack = w_rsp_out.valid & ~w_rsp_out.err & ~reset;
  assign wb_err = w_rsp_out.valid & w_rsp_out.err & ~reset;
  assign wb_data_out = wb_ack ? w_rsp_out.data : '0;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed vector bench for wb_mem_responder (default parameters);
// expectations follow WB_RESP_ADDR_CHECK_EN when it is defined.
module tb_wb_mem_responder;

  localparam logic [63:0] D0 = 64'h1122334455667788;
  localparam logic [63:0] DA = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] DB = 64'h11223344AAAAAAAA;
  localparam logic [63:0] A1 = 64'h1111000000000001;
  localparam logic [63:0] A2 = 64'h2222000000000002;
  localparam logic [63:0] A3 = 64'h3333000000000003;
  localparam logic [63:0] C0 = 64'hC0C0C0C0C0C0C0C0;
  localparam logic [63:0] DX = 64'hDEADBEEF00000400;

`ifdef WB_RESP_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we = 1'b0;
  logic [31:0] wb_addr = '0;
  logic [63:0] wb_data_in = '0;
  logic [7:0]  wb_sel = '0;
  logic        wb_stall;
  logic        wb_ack;
  logic        wb_err;
  logic [63:0] wb_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [63:0] din;
    logic [7:0]  sel;
    logic        est;
    logic        eack;
    logic        eerr;
    logic [63:0] edo;
  } vec_t;

  vec_t vq [$];

  always #5 clk = ~clk;

  wb_mem_responder dut (
    .clock       (clk),
    .reset       (reset),
    .wb_cyc      (wb_cyc),
    .wb_stb      (wb_stb),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data_in  (wb_data_in),
    .wb_sel      (wb_sel),
    .wb_stall    (wb_stall),
    .wb_ack      (wb_ack),
    .wb_err      (wb_err),
    .wb_data_out (wb_data_out)
  );

  task automatic add(
    input logic rst, input logic cyc,
    input logic stb, input logic we,
    input logic [31:0] a, input logic [63:0] d,
    input logic [7:0] s, input logic est,
    input logic eack, input logic eerr,
    input logic [63:0] edo
  );
    vec_t v;
    v.rst = rst; v.cyc = cyc;
    v.stb = stb; v.we = we;
    v.addr = a; v.din = d; v.sel = s;
    v.est = est; v.eack = eack;
    v.eerr = eerr; v.edo = edo;
    vq.push_back(v);
  endtask

  task automatic W(
    input logic [31:0] a, input logic [63:0] d,
    input logic [7:0] s, input logic est,
    input logic eack, input logic [63:0] edo
  );
    add(0, 1, 1, 1, a, d, s, est, eack, 0, edo);
  endtask

  task automatic R(
    input logic [31:0] a, input logic est,
    input logic eack, input logic [63:0] edo
  );
    add(0, 1, 1, 0, a, '0, 8'hFF, est, eack, 0, edo);
  endtask

  task automatic I(
    input logic est, input logic eack,
    input logic eerr, input logic [63:0] edo
  );
    add(0, 1, 0, 0, '0, '0, '0, est, eack, eerr, edo);
  endtask

  task automatic drive(
    input logic rst, input logic cyc,
    input logic stb, input logic we,
    input logic [31:0] a, input logic [63:0] d,
    input logic [7:0] s
  );
    @(posedge clk);
    #1;
    reset = rst; wb_cyc = cyc;
    wb_stb = stb; wb_we = we;
    wb_addr = a; wb_data_in = d; wb_sel = s;
  endtask

  task automatic chk(
    input string nm, input int row,
    input logic [63:0] act, input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h want %h",
               nm, row, act, exp);
    end
  endtask

  initial begin
    int lat;
    int acks;
    bit got;

    // reset
    add(1, 0, 0, 0, '0, '0, '0, 0, 0, 0, '0);
    add(1, 0, 0, 0, '0, '0, '0, 0, 0, 0, '0);
    // full write then read, latency 4
    W(5, D0, 8'hFF, 0, 0, '0);
    R(5, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 1, 0, '0);
    I(0, 1, 0, D0);
    I(0, 0, 0, '0);
    // partial byte write
    W(5, DA, 8'h0F, 0, 0, '0);
    R(5, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 1, 0, '0);
    I(0, 1, 0, DB);
    I(0, 0, 0, '0);
    // preload addresses 1..3
    W(1, A1, 8'hFF, 0, 0, '0);
    W(2, A2, 8'hFF, 0, 0, '0);
    W(3, A3, 8'hFF, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 1, 0, '0);
    I(0, 1, 0, '0);
    I(0, 1, 0, '0);
    I(0, 0, 0, '0);
    // six reads, stall after four
    R(1, 0, 0, '0);
    R(2, 0, 0, '0);
    R(3, 0, 0, '0);
    R(5, 0, 0, '0);
    R(1, 1, 1, A1);
    R(1, 0, 1, A2);
    R(2, 0, 1, A3);
    I(0, 1, 0, DB);
    I(0, 0, 0, '0);
    I(0, 1, 0, A1);
    I(0, 1, 0, A2);
    I(0, 0, 0, '0);
    // three reads then cyc drop
    R(1, 0, 0, '0);
    R(2, 0, 0, '0);
    R(3, 0, 0, '0);
    add(0, 0, 0, 0, '0, '0, '0, 0, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 0, 0, '0);
    R(3, 0, 0, '0);
    R(1, 0, 0, '0);
    R(2, 0, 0, '0);
    R(5, 0, 0, '0);
    I(1, 1, 0, A3);
    I(0, 1, 0, A1);
    I(0, 1, 0, A2);
    I(0, 1, 0, DB);
    I(0, 0, 0, '0);
    // out-of-range address
    W(0, C0, 8'hFF, 0, 0, '0);
    W(32'h400, DX, 8'hFF, 0, 0, '0);
    R(0, 0, 0, '0);
    I(0, 0, 0, '0);
    I(0, 1, 0, '0);
    I(0, !CHK, CHK, '0);
    I(0, 1, 0, CHK ? C0 : DX);
    I(0, 0, 0, '0);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].cyc, vq[i].stb,
            vq[i].we, vq[i].addr, vq[i].din,
            vq[i].sel);
      @(negedge clk);
      chk("stall", i, 64'(wb_stall), 64'(vq[i].est));
      chk("ack", i, 64'(wb_ack), 64'(vq[i].eack));
      chk("err", i, 64'(wb_err), 64'(vq[i].eerr));
      chk("dout", i, wb_data_out, vq[i].edo);
    end

    // reset in the middle of two pending reads
    drive(0, 1, 1, 0, 1, '0, 8'hFF);
    drive(0, 1, 1, 0, 2, '0, 8'hFF);
    drive(1, 1, 1, 0, 3, '0, 8'hFF);
    @(negedge clk);
    chk("rst_stall", 0, 64'(wb_stall), 0);
    chk("rst_ack", 0, 64'(wb_ack), 0);
    acks = 0;
    repeat (8) begin
      drive(0, 1, 0, 0, '0, '0, '0);
      @(negedge clk);
      if (wb_ack || wb_err) acks++;
    end
    chk("no_ack_after_rst", 0, 64'(acks), 0);

    // first request after reset has normal latency
    drive(0, 1, 1, 0, 3, '0, 8'hFF);
    @(negedge clk);
    chk("post_rst_stall", 0, 64'(wb_stall), 0);
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      drive(0, 1, 0, 0, '0, '0, '0);
      lat++;
      @(negedge clk);
      if (wb_ack) begin
        got = 1;
        chk("post_rst_data", 0, wb_data_out, A3);
      end
    end
    chk("post_rst_latency", 0, 64'(lat), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
